// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 validated reader: FSM states,
// error codes, frame byte positions and the frame checksum helper.
package dht11_pkg;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        GUARDA   = 3'd1,
        INICIA   = 3'd2,
        AGUARDA  = 3'd3,
        VERIFICA = 3'd4,
        ENTREGA  = 3'd5,
        FALHA    = 3'd6
    } estado_t;

    localparam logic [1:0] COD_OK           = 2'b00;
    localparam logic [1:0] COD_SEM_RESPOSTA = 2'b01;
    localparam logic [1:0] COD_CHECKSUM     = 2'b10;
    localparam logic [1:0] COD_TIMEOUT      = 2'b11;

    // Byte positions inside the 40-bit frame, counted from the LSB byte.
    localparam int BYTE_UMID_INT = 4;
    localparam int BYTE_UMID_DEC = 3;
    localparam int BYTE_TEMP_INT = 2;
    localparam int BYTE_TEMP_DEC = 1;
    localparam int BYTE_SOMA     = 0;

    function automatic logic [7:0] byte_de(input logic [39:0] quadro, input int idx);
        return quadro[idx*8 +: 8];
    endfunction

    // Sum of the four data bytes modulo 256 must equal the checksum byte.
    function automatic logic checksum_ok(input logic [39:0] quadro);
        logic [9:0] soma;
        soma = 10'(byte_de(quadro, BYTE_UMID_INT)) + 10'(byte_de(quadro, BYTE_UMID_DEC))
             + 10'(byte_de(quadro, BYTE_TEMP_INT)) + 10'(byte_de(quadro, BYTE_TEMP_DEC));
        return soma[7:0] == byte_de(quadro, BYTE_SOMA);
    endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser bank for asynchronous level inputs.
module sincronizador_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First flop may go metastable; second flop presents a settled level.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dht11_leitor_validado.sv
// DHT11 validated reader: triggers the one-wire driver, enforces the
// re-trigger interval, synchronises done/erro, checks the checksum, retries
// and delivers decoded bytes with a one-cycle valido/falha pulse.
// Optional feature: define DHT11_MEDIA_EN to report the integer bytes as the
// mean of the last four valid samples.
module dht11_leitor_validado
    import dht11_pkg::*;
#(
    parameter int MAX_TENTATIVAS = 3,
    parameter int TIMEOUT_CICLOS = 50_000_000,
    parameter int INTERVALO_MIN  = 100_000_000,
    parameter int INICIA_CICLOS  = 100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        requisicao,
    output logic        ocupado,
    output logic        sensor_inicia,
    input  logic        sensor_done,
    input  logic        sensor_erro,
    input  logic [39:0] sensor_dados,
    output logic [7:0]  umidade_int,
    output logic [7:0]  umidade_dec,
    output logic [7:0]  temperatura_int,
    output logic [7:0]  temperatura_dec,
    output logic        valido,
    output logic        falha,
    output logic [1:0]  codigo_erro
);

    localparam int MAX_CICLOS = (TIMEOUT_CICLOS > INICIA_CICLOS) ? TIMEOUT_CICLOS : INICIA_CICLOS;
    localparam int CW = $clog2(MAX_CICLOS + 1);
    localparam int IW = $clog2(INTERVALO_MIN + 1);
    localparam int TW = $clog2(MAX_TENTATIVAS + 1);

    localparam logic [CW-1:0] INICIA_FIM  = CW'(INICIA_CICLOS - 1);
    localparam logic [CW-1:0] TIMEOUT_FIM = CW'(TIMEOUT_CICLOS - 1);
    localparam logic [IW-1:0] INT_SAT     = IW'(INTERVALO_MIN);
    localparam logic [TW-1:0] ULTIMA      = TW'(MAX_TENTATIVAS - 1);

    estado_t       estado;
    logic [CW-1:0] ciclos;
    logic [IW-1:0] intervalo;
    logic [TW-1:0] tentativas;
    logic [39:0]   quadro;
    logic [1:0]    ultimo_cod;

    logic [1:0] sinc_q;
    logic       done_s, erro_s, done_ant, evt_done;
    logic       entra_inicia;
    logic       falhou;
    logic [1:0] cod_novo;
    logic [7:0] umid_int_nova, temp_int_nova;

    sincronizador_2ff #(.WIDTH(2)) u_sinc (
        .clock (clock),
        .reset (reset),
        .d     ({sensor_done, sensor_erro}),
        .q     (sinc_q)
    );

    assign done_s = sinc_q[1];
    assign erro_s = sinc_q[0];

    // Registered rising-edge pulse of the synchronised done level.
    always_ff @(posedge clock) begin
        if (reset) begin
            done_ant <= 1'b0;
            evt_done <= 1'b0;
        end else begin
            done_ant <= done_s;
            evt_done <= done_s & ~done_ant;
        end
    end

    assign entra_inicia = (estado == GUARDA) && (intervalo == INT_SAT);

    // Re-trigger interval: free-running, saturating, cleared as a start pulse begins.
    always_ff @(posedge clock) begin
        if (reset)
            intervalo <= INT_SAT;
        else if (entra_inicia)
            intervalo <= '0;
        else if (intervalo != INT_SAT)
            intervalo <= intervalo + 1'b1;
    end

    // Attempt-failure detection; the FSM turns this into retry or abandon.
    always_comb begin
        falhou   = 1'b0;
        cod_novo = COD_OK;
        case (estado)
            AGUARDA: begin
                if (evt_done && erro_s) begin
                    falhou   = 1'b1;
                    cod_novo = COD_SEM_RESPOSTA;
                end else if (!evt_done && ciclos == TIMEOUT_FIM) begin
                    falhou   = 1'b1;
                    cod_novo = COD_TIMEOUT;
                end
            end
            VERIFICA: begin
                if (!checksum_ok(quadro)) begin
                    falhou   = 1'b1;
                    cod_novo = COD_CHECKSUM;
                end
            end
            default: ;
        endcase
    end

`ifdef DHT11_MEDIA_EN
    logic [7:0] hist_umid [4];
    logic [7:0] hist_temp [4];
    logic [7:0] prox_umid [4];
    logic [7:0] prox_temp [4];
    logic       hist_cheio;
    logic [9:0] soma_umid, soma_temp;

    // Next history window; the first sample after reset fills all four slots.
    always_comb begin
        prox_umid[0] = byte_de(quadro, BYTE_UMID_INT);
        prox_temp[0] = byte_de(quadro, BYTE_TEMP_INT);
        for (int i = 1; i < 4; i++) begin
            prox_umid[i] = hist_cheio ? hist_umid[i-1] : byte_de(quadro, BYTE_UMID_INT);
            prox_temp[i] = hist_cheio ? hist_temp[i-1] : byte_de(quadro, BYTE_TEMP_INT);
        end
        soma_umid = 10'(prox_umid[0]) + 10'(prox_umid[1]) + 10'(prox_umid[2]) + 10'(prox_umid[3]);
        soma_temp = 10'(prox_temp[0]) + 10'(prox_temp[1]) + 10'(prox_temp[2]) + 10'(prox_temp[3]);
        umid_int_nova = soma_umid[9:2];
        temp_int_nova = soma_temp[9:2];
    end

    // History advances only when a validated sample is delivered.
    always_ff @(posedge clock) begin
        if (reset) begin
            hist_cheio <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                hist_umid[i] <= '0;
                hist_temp[i] <= '0;
            end
        end else if (estado == ENTREGA) begin
            hist_cheio <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                hist_umid[i] <= prox_umid[i];
                hist_temp[i] <= prox_temp[i];
            end
        end
    end
`else
    assign umid_int_nova = byte_de(quadro, BYTE_UMID_INT);
    assign temp_int_nova = byte_de(quadro, BYTE_TEMP_INT);
`endif

    // Main control FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado          <= OCIOSO;
            ocupado         <= 1'b0;
            sensor_inicia   <= 1'b0;
            valido          <= 1'b0;
            falha           <= 1'b0;
            codigo_erro     <= COD_OK;
            umidade_int     <= '0;
            umidade_dec     <= '0;
            temperatura_int <= '0;
            temperatura_dec <= '0;
            tentativas      <= '0;
            ciclos          <= '0;
            quadro          <= '0;
            ultimo_cod      <= COD_OK;
        end else begin
            valido <= 1'b0;
            falha  <= 1'b0;
            if (falhou) begin
                ultimo_cod <= cod_novo;
                ciclos     <= '0;
                if (tentativas == ULTIMA) begin
                    estado <= FALHA;
                end else begin
                    tentativas <= tentativas + 1'b1;
                    estado     <= GUARDA;
                end
            end else begin
                case (estado)
                    OCIOSO: begin
                        // ocupado still high here means valido/falha is on the
                        // outputs this cycle, so a request now is dropped.
                        if (ocupado) begin
                            ocupado <= 1'b0;
                        end else if (requisicao) begin
                            ocupado    <= 1'b1;
                            tentativas <= '0;
                            estado     <= GUARDA;
                        end
                    end
                    GUARDA: begin
                        if (entra_inicia) begin
                            sensor_inicia <= 1'b1;
                            ciclos        <= '0;
                            estado        <= INICIA;
                        end
                    end
                    INICIA: begin
                        if (ciclos == INICIA_FIM) begin
                            sensor_inicia <= 1'b0;
                            ciclos        <= '0;
                            estado        <= AGUARDA;
                        end else begin
                            ciclos <= ciclos + 1'b1;
                        end
                    end
                    AGUARDA: begin
                        if (evt_done) begin
                            quadro <= sensor_dados;
                            estado <= VERIFICA;
                        end else begin
                            ciclos <= ciclos + 1'b1;
                        end
                    end
                    VERIFICA: estado <= ENTREGA;
                    ENTREGA: begin
                        valido          <= 1'b1;
                        codigo_erro     <= COD_OK;
                        umidade_int     <= umid_int_nova;
                        umidade_dec     <= byte_de(quadro, BYTE_UMID_DEC);
                        temperatura_int <= temp_int_nova;
                        temperatura_dec <= byte_de(quadro, BYTE_TEMP_DEC);
                        estado          <= OCIOSO;
                    end
                    FALHA: begin
                        falha       <= 1'b1;
                        codigo_erro <= ultimo_cod;
                        estado      <= OCIOSO;
                    end
                    default: estado <= OCIOSO;
                endcase
            end
        end
    end

endmodule
